ifft8_stream: RTL and testbench

//  8-point radix-2 DIT inverse FFT: the return path for the 8-point forward FFT datapath.

---
 rtl/fft_pkg.sv | 13 +
 rtl/ifft8_stream_if.sv | 25 ++
 rtl/ifft_twiddle_mul.sv | 41 ++++
 rtl/ifft8_stream.sv | 127 ++++++++++++
 tb/tb_ifft8_stream.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, state type and index helper for the 8-point FFT/IFFT datapaths.
package fft_pkg;

  localparam int FRAC = 8;
  localparam logic [15:0] C0707 = 16'd180;

  typedef enum logic [2:0] {LOAD, S1, S2, S3, OUT} state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/ifft8_stream_if.sv
// Input/output sample streams of the 8-point IFFT block.
interface ifft8_stream_if #(parameter int DW = 16);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic                 out_last;
  logic                 busy;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_last, busy
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_last, busy
  );

endinterface

// File: rtl/ifft_twiddle_mul.sv
// Combinational multiply by W^-1 = c(1+j) (sel=0) or W^-3 = c(-1+j) (sel=1).
module ifft_twiddle_mul
  import fft_pkg::*;
#(
  parameter int IW = 19
) (
  input  logic signed [IW-1:0] re,
  input  logic signed [IW-1:0] im,
  input  logic                 sel,
  output logic signed [IW-1:0] re_out,
  output logic signed [IW-1:0] im_out
);

  // Sign-magnitude multiply by c so the result truncates toward zero.
  function automatic logic signed [IW-1:0] cmul(input logic signed [IW-1:0] x);
    logic [IW-1:0]      mag;
    logic [IW+FRAC-1:0] prod;
    logic [IW-1:0]      q;
    mag  = x[IW-1] ? $unsigned(-x) : $unsigned(x);
    prod = (IW+FRAC)'(mag) * (IW+FRAC)'(C0707);
    q    = IW'(prod >> FRAC);
    return x[IW-1] ? -$signed(q) : $signed(q);
  endfunction

  logic signed [IW-1:0] sum;
  logic signed [IW-1:0] dif;

  // (a+jb)(1+j) = (a-b) + j(a+b);  (a+jb)(-1+j) = -(a+b) + j(a-b)
  always_comb begin
    sum = re + im;
    dif = re - im;
    if (!sel) begin
      re_out = cmul(dif);
      im_out = cmul(sum);
    end else begin
      re_out = -cmul(sum);
      im_out = cmul(dif);
    end
  end

endmodule

// File: rtl/ifft8_stream.sv
// 8-point radix-2 DIT inverse FFT, one butterfly stage per clock, streaming in/out.
module ifft8_stream
  import fft_pkg::*;
#(
  parameter int DW = 16,
  parameter int GW = 3
) (
  input  logic           clk,
  input  logic           rst,
  ifft8_stream_if.slave  s
);

  localparam int IW = DW + GW;

  state_t               state;
  logic [2:0]           cnt;
  logic signed [IW-1:0] mem_re [8];
  logic signed [IW-1:0] mem_im [8];
  logic signed [IW-1:0] stg_re [8];
  logic signed [IW-1:0] stg_im [8];
  logic signed [IW-1:0] t5_re, t5_im, t7_re, t7_im;

  ifft_twiddle_mul #(.IW(IW)) u_tw5 (
    .re(mem_re[5]), .im(mem_im[5]), .sel(1'b0), .re_out(t5_re), .im_out(t5_im)
  );

  ifft_twiddle_mul #(.IW(IW)) u_tw7 (
    .re(mem_re[7]), .im(mem_im[7]), .sel(1'b1), .re_out(t7_re), .im_out(t7_im)
  );

  // Next-buffer contents for the butterfly stage selected by the current state.
  always_comb begin
    stg_re = mem_re;
    stg_im = mem_im;
    case (state)
      S1: begin
        for (int unsigned g = 0; g < 4; g++) begin
          stg_re[3'(2*g)]   = mem_re[3'(2*g)] + mem_re[3'(2*g+1)];
          stg_im[3'(2*g)]   = mem_im[3'(2*g)] + mem_im[3'(2*g+1)];
          stg_re[3'(2*g+1)] = mem_re[3'(2*g)] - mem_re[3'(2*g+1)];
          stg_im[3'(2*g+1)] = mem_im[3'(2*g)] - mem_im[3'(2*g+1)];
        end
      end
      S2: begin
        for (int unsigned g = 0; g < 2; g++) begin
          stg_re[3'(4*g)]   = mem_re[3'(4*g)] + mem_re[3'(4*g+2)];
          stg_im[3'(4*g)]   = mem_im[3'(4*g)] + mem_im[3'(4*g+2)];
          stg_re[3'(4*g+2)] = mem_re[3'(4*g)] - mem_re[3'(4*g+2)];
          stg_im[3'(4*g+2)] = mem_im[3'(4*g)] - mem_im[3'(4*g+2)];
          // +j twiddle: j(a+jb) = -b + ja
          stg_re[3'(4*g+1)] = mem_re[3'(4*g+1)] - mem_im[3'(4*g+3)];
          stg_im[3'(4*g+1)] = mem_im[3'(4*g+1)] + mem_re[3'(4*g+3)];
          stg_re[3'(4*g+3)] = mem_re[3'(4*g+1)] + mem_im[3'(4*g+3)];
          stg_im[3'(4*g+3)] = mem_im[3'(4*g+1)] - mem_re[3'(4*g+3)];
        end
      end
      S3: begin
        stg_re[0] = mem_re[0] + mem_re[4];
        stg_im[0] = mem_im[0] + mem_im[4];
        stg_re[4] = mem_re[0] - mem_re[4];
        stg_im[4] = mem_im[0] - mem_im[4];
        stg_re[1] = mem_re[1] + t5_re;
        stg_im[1] = mem_im[1] + t5_im;
        stg_re[5] = mem_re[1] - t5_re;
        stg_im[5] = mem_im[1] - t5_im;
        stg_re[2] = mem_re[2] - mem_im[6];
        stg_im[2] = mem_im[2] + mem_re[6];
        stg_re[6] = mem_re[2] + mem_im[6];
        stg_im[6] = mem_im[2] - mem_re[6];
        stg_re[3] = mem_re[3] + t7_re;
        stg_im[3] = mem_im[3] + t7_im;
        stg_re[7] = mem_re[3] - t7_re;
        stg_im[7] = mem_im[3] - t7_im;
      end
      default: ;
    endcase
  end

  // Control: load 8 samples, three butterfly stages, then drain 8 results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      case (state)
        LOAD: if (s.in_valid) begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= S1;
        end
        S1: state <= S2;
        S2: state <= S3;
        S3: state <= OUT;
        OUT: if (s.out_ready) begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Working buffer: bit-reversed sample writes during LOAD, in-place stage updates after.
  always_ff @(posedge clk) begin
    if (state == LOAD && s.in_valid) begin
      mem_re[bitrev3(cnt)] <= {{GW{s.in_real[DW-1]}}, s.in_real};
      mem_im[bitrev3(cnt)] <= {{GW{s.in_imag[DW-1]}}, s.in_imag};
    end else if (state inside {S1, S2, S3}) begin
      mem_re <= stg_re;
      mem_im <= stg_im;
    end
  end

  // Stream outputs; the 1/8 scaling is an arithmetic shift of the stored word.
  always_comb begin
    s.in_ready  = (state == LOAD);
    s.busy      = (state != LOAD);
    s.out_valid = (state == OUT);
    s.out_last  = (state == OUT) && (cnt == 3'd7);
    s.out_real  = '0;
    s.out_imag  = '0;
    if (state == OUT) begin
      s.out_real = DW'(mem_re[cnt] >>> GW);
      s.out_imag = DW'(mem_im[cnt] >>> GW);
    end
  end

endmodule

// File: tb/tb_ifft8_stream.sv
// Self-checking bench for ifft8_stream: directed frames plus randomized round-trip frames.
module tb_ifft8_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   t_acc = 0;
  int   t_val = 0;

  int fr [8];
  int fi [8];
  int er [8];
  int ei [8];

  ifft8_stream_if #(.DW(16)) bus ();

  ifft8_stream #(.DW(16), .GW(3)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    tests++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  longint'(bus.in_ready), 1, 0);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0, 0);
    check({tag, "_out_last"},  longint'(bus.out_last), 0, 0);
    check({tag, "_busy"},      longint'(bus.busy), 0, 0);
    check({tag, "_out_real"},  longint'(bus.out_real), 0, 0);
    check({tag, "_out_imag"},  longint'(bus.out_imag), 0, 0);
  endtask

  // Ideal inverse DFT using the block's quantised constant c = 180/256 on odd twiddles.
  function automatic void ref_ifft(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
    real c;
    real wr [8];
    real wi [8];
    real sr, si;
    int  m;
    c  = 180.0 / 256.0;
    wr = '{1.0, c, 0.0, -c, -1.0, -c, 0.0, c};
    wi = '{0.0, c, 1.0, c, 0.0, -c, -1.0, -c};
    for (int n = 0; n < 8; n++) begin
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < 8; k++) begin
        m  = (n * k) % 8;
        sr = sr + xr[k] * wr[m] - xi[k] * wi[m];
        si = si + xr[k] * wi[m] + xi[k] * wr[m];
      end
      yr[n] = $rtoi($floor(sr / 8.0 + 0.5));
      yi[n] = $rtoi($floor(si / 8.0 + 0.5));
    end
  endfunction

  // Exact forward DFT of a time-domain frame, rounded to integers.
  function automatic void fwd_dft(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
    real sr, si, th;
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        th = 2.0 * 3.14159265358979 * n * k / 8.0;
        sr = sr + xr[n] * $cos(th) + xi[n] * $sin(th);
        si = si + xi[n] * $cos(th) - xr[n] * $sin(th);
      end
      yr[k] = $rtoi($floor(sr + 0.5));
      yi[k] = $rtoi($floor(si + 0.5));
    end
  endfunction

  // Present the first cnt samples of a frame, optionally with idle gaps on in_valid.
  task automatic send_frame(input int xr[8], input int xi[8], input int cnt, input bit gaps);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < cnt && guard < 200) begin
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_real  = 16'($urandom);
        bus.in_imag  = 16'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_real  = 16'(xr[k]);
        bus.in_imag  = 16'(xi[k]);
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc && k == 7) t_acc = cyc + 1;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    if (k < cnt) check("send_timeout", k, cnt, 0);
  endtask

  // Drain one frame, checking each word; optionally stall 5 cycles at word hold_at.
  task automatic recv_frame(input int yr[8], input int yi[8], input int tol, input int hold_at, input bit rnd);
    int n = 0;
    int guard = 0;
    int held = 0;
    bit first = 1'b1;
    bit rdy;
    while (n < 8 && guard < 400) begin
      guard++;
      if (bus.out_valid) begin
        if (first) begin
          first = 1'b0;
          t_val = cyc + 1;
        end
        if (n == hold_at && held < 5) rdy = 1'b0;
        else if (rnd) rdy = ($urandom_range(0, 3) != 0);
        else rdy = 1'b1;
        bus.out_ready = rdy;
        check("out_real", longint'(bus.out_real), yr[n], tol);
        check("out_imag", longint'(bus.out_imag), yi[n], tol);
        check("out_last", longint'(bus.out_last), (n == 7) ? 1 : 0, 0);
        check("in_ready_out", longint'(bus.in_ready), 0, 0);
        if (!rdy) held++;
        @(posedge clk);
        #1;
        if (rdy) n++;
      end else begin
        bus.out_ready = 1'b0;
        check("in_ready_wait", longint'(bus.in_ready), 0, 0);
        @(posedge clk);
        #1;
      end
    end
    bus.out_ready = 1'b0;
    if (n < 8) check("recv_timeout", n, 8, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int xr [8];
    int xi [8];
    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Impulse at X[0]: flat time-domain output, latency check on X[7] acceptance.
    fr = '{default: 0};
    fi = '{default: 0};
    fr[0] = 16'h0800;
    er = '{default: 256};
    ei = '{default: 0};
    send_frame(fr, fi, 8, 1'b0);
    recv_frame(er, ei, 0, -1, 1'b0);
    check("latency", t_val - t_acc, 4, 0);
    check_idle("after_impulse");

    // Single tone at X[1] with a 5-cycle output stall at x[3].
    fr = '{default: 0};
    fr[1] = 16'h0800;
    er = '{256, 180, 0, -180, -256, -180, 0, 180};
    ei = '{0, 180, 256, 180, 0, -180, -256, -180};
    send_frame(fr, fi, 8, 1'b1);
    recv_frame(er, ei, 0, 3, 1'b0);

    // Abort a partial frame with reset, then a clean impulse frame.
    for (int i = 0; i < 8; i++) begin
      fr[i] = int'($urandom_range(0, 4000)) - 2000;
      fi[i] = int'($urandom_range(0, 4000)) - 2000;
    end
    send_frame(fr, fi, 5, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("mid_reset");
    rst = 1'b0;
    fr = '{default: 0};
    fi = '{default: 0};
    fr[0] = 16'h0800;
    er = '{default: 256};
    ei = '{default: 0};
    send_frame(fr, fi, 8, 1'b1);
    recv_frame(er, ei, 0, -1, 1'b0);

    // Random round trips: time-domain frame -> forward DFT -> DUT.
    for (int f = 0; f < 200; f++) begin
      for (int i = 0; i < 8; i++) begin
        xr[i] = int'($urandom_range(0, 2048)) - 1024;
        xi[i] = int'($urandom_range(0, 2048)) - 1024;
      end
      fwd_dft(xr, xi, fr, fi);
      ref_ifft(fr, fi, er, ei);
      send_frame(fr, fi, 8, 1'b1);
      recv_frame(er, ei, 2, -1, 1'b1);
    end
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
